// File: rtl/booth_control_unit.sv
// rtl/booth_control_unit.sv - Sequencing FSM for the radix-2 Booth multiplier datapath.
// Owns the iteration counter only; the A/Q/Q-1/M registers and the adder live in the datapath.
module booth_control_unit #(
   parameter int WIDTH = 32,
   parameter int CW    = $clog2(WIDTH + 1)
) (
   input  logic          clk,
   input  logic          rst_n,
   input  logic          start,
   input  logic          q0,
   input  logic          q_m1,
   output logic          load,
   output logic          add,
   output logic          sub,
   output logic          shift,
   output logic          busy,
   output logic          done,
   output logic [CW-1:0] count
);

   typedef enum logic [1:0] {IDLE, LOAD, RUN, DONE} state_t;

   state_t state;

   // Moore outputs are registered alongside the state so they follow the next state exactly.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state <= IDLE;
         load  <= 1'b0;
         shift <= 1'b0;
         busy  <= 1'b0;
         done  <= 1'b0;
         count <= '0;
      end else begin
         load  <= 1'b0;
         shift <= 1'b0;
         done  <= 1'b0;
         case (state)
            IDLE: begin
               if (start) begin
                  state <= LOAD;
                  load  <= 1'b1;
                  busy  <= 1'b1;
               end
            end
            LOAD: begin
               state <= RUN;
               shift <= 1'b1;
               count <= CW'(WIDTH);
            end
            RUN: begin
               count <= count - CW'(1);
               if (count == CW'(1)) begin
                  state <= DONE;
                  done  <= 1'b1;
               end else begin
                  shift <= 1'b1;
               end
            end
            DONE: begin
               state <= IDLE;
               busy  <= 1'b0;
               count <= '0;
            end
            default: begin
               state <= IDLE;
               busy  <= 1'b0;
               count <= '0;
            end
         endcase
      end
   end

   // Booth recoding of the current {Q0, Q-1} pair, valid only while iterating.
   assign sub = (state == RUN) &&  q0 && !q_m1;
   assign add = (state == RUN) && !q0 &&  q_m1;

endmodule

// File: tb/tb_booth_control_unit.sv
// tb/tb_booth_control_unit.sv - Self-checking bench for booth_control_unit at WIDTH=32 and WIDTH=4.
module tb_booth_control_unit;

   logic       clk;
   logic       rst_n;
   logic       start;
   logic       q0;
   logic       q_m1;
   logic       load32, add32, sub32, shift32, busy32, done32;
   logic [5:0] count32;
   logic       load4, add4, sub4, shift4, busy4, done4;
   logic [2:0] count4;

   int checks = 0;
   int errors = 0;
   bit mon_en = 0;
   int t32 = -1;
   int t4  = -1;

   typedef struct {
      bit q0;
      bit qm1;
      bit exp_add;
      bit exp_sub;
   } dvec_t;
   dvec_t tab [4];

   booth_control_unit #(.WIDTH(32)) dut32 (
      .clk(clk), .rst_n(rst_n), .start(start), .q0(q0), .q_m1(q_m1),
      .load(load32), .add(add32), .sub(sub32), .shift(shift32),
      .busy(busy32), .done(done32), .count(count32)
   );

   booth_control_unit #(.WIDTH(4)) dut4 (
      .clk(clk), .rst_n(rst_n), .start(start), .q0(q0), .q_m1(q_m1),
      .load(load4), .add(add4), .sub(sub4), .shift(shift4),
      .busy(busy4), .done(done4), .count(count4)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s actual %0d expected %0d at %0t", nm, act, exp, $time);
      end
   endtask

   // Reference: t is the cycle index since the accepted start (1 = load cycle), -1 when idle.
   function automatic int next_t(input int t, input int w, input bit st);
      if (t < 0)          return st ? 1 : -1;
      else if (t >= w + 2) return -1;
      else                return t + 1;
   endfunction

   always @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         t32 = -1;
         t4  = -1;
      end else begin
         t32 = next_t(t32, 32, start);
         t4  = next_t(t4, 4, start);
      end
   end

   task automatic cmp(input string tag, input int t, input int w,
                      input logic ld, input logic ad, input logic sb, input logic sh,
                      input logic bz, input logic dn, input logic [31:0] cnt);
      bit run;
      run = (t >= 2) && (t <= w + 1);
      check({tag, "_load"},  32'(ld), 32'(t == 1));
      check({tag, "_add"},   32'(ad), 32'(run && !q0 && q_m1));
      check({tag, "_sub"},   32'(sb), 32'(run && q0 && !q_m1));
      check({tag, "_shift"}, 32'(sh), 32'(run));
      check({tag, "_busy"},  32'(bz), 32'(t >= 1));
      check({tag, "_done"},  32'(dn), 32'(t == w + 2));
      check({tag, "_count"}, cnt, run ? 32'(w - (t - 2)) : 32'd0);
   endtask

   always @(negedge clk) begin
      if (mon_en) begin
         cmp("w32", t32, 32, load32, add32, sub32, shift32, busy32, done32, 32'(count32));
         cmp("w4",  t4,  4,  load4,  add4,  sub4,  shift4,  busy4,  done4,  32'(count4));
      end
   end

   task automatic settle(input int n);
      repeat (n) @(posedge clk);
      #1;
   endtask

   // Pulses start and returns the cycle index of the first done pulse on each instance.
   task automatic run_op(input bit poke, output int n32, output int n4);
      int n;
      start = 1'b1;
      @(posedge clk);
      #1;
      n = 1; n32 = 0; n4 = 0;
      check("op_load_first", 32'(load32), 32'd1);
      start = poke;
      while (n32 == 0 && n < 100) begin
         @(posedge clk);
         #1;
         n++;
         if (done32 && n32 == 0) n32 = n;
         if (done4 && n4 == 0)   n4 = n;
         start = poke && (n == 17 || n == 34);
      end
      @(posedge clk);
      #1;
      start = 1'b0;
      check("op_idle_after_done", 32'(busy32), 32'd0);
      check("op_no_second_done", 32'(done32), 32'd0);
   endtask

   initial begin
      int n32, n4, c, first, second;
      tab[0] = '{q0: 1'b1, qm1: 1'b0, exp_add: 1'b0, exp_sub: 1'b1};
      tab[1] = '{q0: 1'b0, qm1: 1'b1, exp_add: 1'b1, exp_sub: 1'b0};
      tab[2] = '{q0: 1'b1, qm1: 1'b1, exp_add: 1'b0, exp_sub: 1'b0};
      tab[3] = '{q0: 1'b0, qm1: 1'b0, exp_add: 1'b0, exp_sub: 1'b0};

      rst_n = 1'b0;
      start = 1'b1;
      q0    = 1'($urandom);
      q_m1  = 1'($urandom);
      #1 mon_en = 1;
      repeat (3) @(posedge clk);
      #1;
      check("rst_load",  32'(load32),  32'd0);
      check("rst_add",   32'(add32),   32'd0);
      check("rst_sub",   32'(sub32),   32'd0);
      check("rst_shift", 32'(shift32), 32'd0);
      check("rst_busy",  32'(busy32),  32'd0);
      check("rst_done",  32'(done32),  32'd0);
      check("rst_count", 32'(count32), 32'd0);
      start = 1'b0;
      q0    = 1'b0;
      q_m1  = 1'b0;
      rst_n = 1'b1;

      run_op(1'b0, n32, n4);
      check("len_w32", 32'(n32), 32'd34);
      check("len_w4",  32'(n4),  32'd6);
      settle(8);

      start = 1'b1;
      @(posedge clk);
      #1;
      start = 1'b0;
      @(posedge clk);
      #1;
      for (int i = 0; i < 4; i++) begin
         q0   = tab[i].q0;
         q_m1 = tab[i].qm1;
         #1;
         check("dec_add",   32'(add32),   32'(tab[i].exp_add));
         check("dec_sub",   32'(sub32),   32'(tab[i].exp_sub));
         check("dec_shift", 32'(shift32), 32'd1);
         @(posedge clk);
         #1;
      end
      q0   = 1'b0;
      q_m1 = 1'b0;
      settle(40);

      run_op(1'b1, n32, n4);
      check("len_poked", 32'(n32), 32'd34);
      settle(8);

      start = 1'b1;
      first = 0;
      second = 0;
      for (int k = 1; k <= 200 && second == 0; k++) begin
         @(posedge clk);
         #1;
         if (done32 && first == 0)      first = k;
         else if (done32 && first != 0) second = k;
      end
      start = 1'b0;
      check("b2b_period", 32'(second - first), 32'd35);
      settle(40);

      start = 1'b1;
      @(posedge clk);
      #1;
      start = 1'b0;
      c = 0;
      while (count32 !== 6'd17 && c < 100) begin
         @(posedge clk);
         #1;
         c++;
      end
      check("reach_17", 32'(count32), 32'd17);
      #2 rst_n = 1'b0;
      #1;
      check("arst_busy32",  32'(busy32),  32'd0);
      check("arst_shift32", 32'(shift32), 32'd0);
      check("arst_count32", 32'(count32), 32'd0);
      check("arst_busy4",   32'(busy4),   32'd0);
      repeat (2) @(posedge clk);
      #1;
      check("arst_no_done", 32'(done32), 32'd0);
      rst_n = 1'b1;
      run_op(1'b0, n32, n4);
      check("len_after_rst", 32'(n32), 32'd34);
      settle(8);

      for (int k = 0; k < 400; k++) begin
         q0    = 1'($urandom);
         q_m1  = 1'($urandom);
         start = ($urandom_range(0, 5) == 0);
         @(posedge clk);
         #1;
      end
      start = 1'b0;
      settle(40);

      mon_en = 0;
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
